// File: rtl/beam_pkg.sv
// rtl/beam_pkg.sv - shared states, mode constants and default widths for the beam tracker
package beam_pkg;

    localparam int DEF_LINE_WIDTH   = 160;
    localparam int DEF_COUNT_WIDTH  = 48;
    localparam int DEF_RESULT_WIDTH = 64;

    localparam logic MODE_SPLITS    = 1'b0;
    localparam logic MODE_TIMELINES = 1'b1;

    typedef enum logic [1:0] {
        ST_START,
        ST_ACTIVE,
        ST_SUM,
        ST_DONE
    } beam_state_t;

endpackage

// File: rtl/timeline_summer.sv
// rtl/timeline_summer.sv - serial saturating accumulator over the column array
module timeline_summer
    import beam_pkg::*;
#(
    parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
    localparam int IDX_W       = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    output logic [IDX_W-1:0]        o_col_idx,
    input  logic [COUNT_WIDTH-1:0]  i_col_value,
    output logic                    o_done,
    output logic [RESULT_WIDTH-1:0] o_sum,
    output logic                    o_saturated
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WIDTH - 1);

    logic                    r_busy;
    logic [IDX_W-1:0]        r_idx;
    logic [RESULT_WIDTH-1:0] r_acc;
    logic                    r_sat;
    logic                    r_done;
    logic [RESULT_WIDTH:0]   w_add;

    // One spare bit on top catches the carry that means saturation.
    assign w_add = {1'b0, r_acc} + {{(RESULT_WIDTH + 1 - COUNT_WIDTH){1'b0}}, i_col_value};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_idx  <= '0;
            r_acc  <= '0;
            r_sat  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_idx  <= '0;
                r_acc  <= '0;
                r_sat  <= 1'b0;
            end else if (r_busy) begin
                if (w_add[RESULT_WIDTH]) begin
                    r_acc <= '1;
                    r_sat <= 1'b1;
                end else begin
                    r_acc <= w_add[RESULT_WIDTH-1:0];
                end
                if (r_idx == LAST_IDX) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign o_col_idx   = r_idx;
    assign o_done      = r_done;
    assign o_sum       = r_acc;
    assign o_saturated = r_sat;

endmodule

// File: rtl/beam_timeline_tracker.sv
// rtl/beam_timeline_tracker.sv - per-column beam multiplicity tracker reporting splits or timelines
module beam_timeline_tracker
    import beam_pkg::*;
#(
    parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic                    line_valid,
    output logic                    line_ready,
    input  logic [LINE_WIDTH-1:0]   line_data,
    input  logic                    end_of_file,
    output logic                    result_valid,
    output logic [RESULT_WIDTH-1:0] result_data,
    output logic                    overflow
);
    localparam int IDX_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int SUM_W = COUNT_WIDTH + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = {2'b00, {COUNT_WIDTH{1'b1}}};

    beam_state_t             r_state;
    beam_state_t             w_state_next;
    logic                    r_mode;
    logic                    r_line_ready;
    logic                    r_result_valid;
    logic                    r_overflow;
    logic [RESULT_WIDTH-1:0] r_splits;
    logic [RESULT_WIDTH-1:0] r_pending;
    logic [RESULT_WIDTH-1:0] r_result_data;
    logic [COUNT_WIDTH-1:0]  r_cnt      [LINE_WIDTH];
    logic [COUNT_WIDTH-1:0]  w_cnt_next [LINE_WIDTH];
    logic [LINE_WIDTH-1:0]   w_hit;
    logic [LINE_WIDTH-1:0]   w_col_sat;
    logic                    w_accept;
    logic                    w_load_start;
    logic                    w_load_line;
    logic                    w_sum_start;
    logic                    w_sum_done;
    logic                    w_sum_sat;
    logic [IDX_W-1:0]        w_col_idx;
    logic [RESULT_WIDTH-1:0] w_sum;

    assign w_accept = line_valid && r_line_ready;

    // Each column keeps its beams unless it is a splitter, and collects the beams split off its neighbours.
    for (genvar c = 0; c < LINE_WIDTH; c++) begin : g_col
        logic [SUM_W-1:0] w_keep;
        logic [SUM_W-1:0] w_left;
        logic [SUM_W-1:0] w_right;
        logic [SUM_W-1:0] w_total;

        assign w_hit[c] = line_data[c] && (r_cnt[c] != '0);
        assign w_keep   = line_data[c] ? '0 : {2'b00, r_cnt[c]};

        if (c > 0) begin : g_left
            assign w_left = w_hit[c-1] ? {2'b00, r_cnt[c-1]} : '0;
        end else begin : g_no_left
            assign w_left = '0;
        end

        if (c < LINE_WIDTH - 1) begin : g_right
            assign w_right = w_hit[c+1] ? {2'b00, r_cnt[c+1]} : '0;
        end else begin : g_no_right
            assign w_right = '0;
        end

        assign w_total       = w_keep + w_left + w_right;
        assign w_col_sat[c]  = (w_total > CNT_MAX);
        assign w_cnt_next[c] = w_col_sat[c] ? '1 : w_total[COUNT_WIDTH-1:0];
    end

    always_comb begin
        w_state_next = r_state;
        w_load_start = 1'b0;
        w_load_line  = 1'b0;
        w_sum_start  = 1'b0;
        case (r_state)
            ST_START: begin
                if (w_accept) begin
                    w_load_start = 1'b1;
                    w_state_next = end_of_file ? ST_SUM : ST_ACTIVE;
                    w_sum_start  = end_of_file && (mode == MODE_TIMELINES);
                end else if (end_of_file) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_ACTIVE: begin
                w_load_line = w_accept;
                if (end_of_file) begin
                    w_state_next = ST_SUM;
                    w_sum_start  = (r_mode == MODE_TIMELINES);
                end
            end
            ST_SUM: begin
                if ((r_mode == MODE_SPLITS) || w_sum_done) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_START;
            end
            default: begin
                w_state_next = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_START;
            r_mode         <= MODE_SPLITS;
            r_line_ready   <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_data  <= '0;
            r_overflow     <= 1'b0;
            r_splits       <= '0;
            r_pending      <= '0;
        end else begin
            r_state        <= w_state_next;
            r_line_ready   <= (w_state_next == ST_START) || (w_state_next == ST_ACTIVE);
            r_result_valid <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                r_result_data <= r_pending;
            end
            if (w_load_start) begin
                r_mode     <= mode;
                r_splits   <= '0;
                r_overflow <= 1'b0;
            end
            if (w_load_line) begin
                r_splits <= r_splits + RESULT_WIDTH'($countones(w_hit));
                if (|w_col_sat) begin
                    r_overflow <= 1'b1;
                end
            end
            if ((r_state == ST_START) && (w_state_next == ST_DONE)) begin
                r_pending <= '0;
            end
            if ((r_state == ST_SUM) && (w_state_next == ST_DONE)) begin
                r_pending <= (r_mode == MODE_SPLITS) ? r_splits : w_sum;
                if ((r_mode == MODE_TIMELINES) && w_sum_sat) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINE_WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_load_start) begin
            for (int i = 0; i < LINE_WIDTH; i++) begin
                r_cnt[i] <= COUNT_WIDTH'(line_data[i]);
            end
        end else if (w_load_line) begin
            for (int i = 0; i < LINE_WIDTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    timeline_summer #(
        .LINE_WIDTH   (LINE_WIDTH),
        .COUNT_WIDTH  (COUNT_WIDTH),
        .RESULT_WIDTH (RESULT_WIDTH)
    ) u_summer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_sum_start),
        .o_col_idx   (w_col_idx),
        .i_col_value (r_cnt[w_col_idx]),
        .o_done      (w_sum_done),
        .o_sum       (w_sum),
        .o_saturated (w_sum_sat)
    );

    assign line_ready   = r_line_ready;
    assign result_valid = r_result_valid;
    assign result_data  = r_result_data;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_beam_timeline_tracker.sv
// tb/tb_beam_timeline_tracker.sv - directed and randomized checks of beam_timeline_tracker against a beam model
module tb_beam_timeline_tracker;

    typedef logic [15:0] line_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tb_mode;
    logic        tb_valid;
    line_t       tb_data;
    logic        tb_eof;
    int          sel;

    logic        rdy0, rdy1, rdy2;
    logic        rv0, rv1, rv2;
    logic [63:0] rd0, rd1, rd2;
    logic        ov0, ov1, ov2;

    logic        m_ready, m_rv, m_ov;
    logic [63:0] m_rd;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    line_t           q_lines[$];
    longint unsigned m_cnt[16];
    longint unsigned m_splits;
    longint unsigned m_tl;
    bit              m_ovf;

    always #5 clk = ~clk;

    beam_timeline_tracker #(.LINE_WIDTH(16), .COUNT_WIDTH(48), .RESULT_WIDTH(64)) u_main (
        .clk(clk), .rst_n(rst_n), .mode(tb_mode), .line_valid(tb_valid && (sel == 0)),
        .line_ready(rdy0), .line_data(tb_data), .end_of_file(tb_eof && (sel == 0)),
        .result_valid(rv0), .result_data(rd0), .overflow(ov0));

    beam_timeline_tracker #(.LINE_WIDTH(15), .COUNT_WIDTH(48), .RESULT_WIDTH(64)) u_puzzle (
        .clk(clk), .rst_n(rst_n), .mode(tb_mode), .line_valid(tb_valid && (sel == 1)),
        .line_ready(rdy1), .line_data(tb_data[14:0]), .end_of_file(tb_eof && (sel == 1)),
        .result_valid(rv1), .result_data(rd1), .overflow(ov1));

    beam_timeline_tracker #(.LINE_WIDTH(16), .COUNT_WIDTH(2), .RESULT_WIDTH(64)) u_sat (
        .clk(clk), .rst_n(rst_n), .mode(tb_mode), .line_valid(tb_valid && (sel == 2)),
        .line_ready(rdy2), .line_data(tb_data), .end_of_file(tb_eof && (sel == 2)),
        .result_valid(rv2), .result_data(rd2), .overflow(ov2));

    always_comb begin
        m_ready = rdy0;
        m_rv    = rv0;
        m_rd    = rd0;
        m_ov    = ov0;
        if (sel == 1) begin
            m_ready = rdy1; m_rv = rv1; m_rd = rd1; m_ov = ov1;
        end else if (sel == 2) begin
            m_ready = rdy2; m_rv = rv2; m_rd = rd2; m_ov = ov2;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Beams move as whole bundles: a struck splitter sends its bundle to both neighbours.
    function automatic void run_model(input int width, input int cw);
        longint unsigned mx;
        longint unsigned nxt[16];
        mx = (64'd1 << cw) - 64'd1;
        m_splits = 0;
        m_ovf    = 1'b0;
        for (int c = 0; c < 16; c++) begin
            m_cnt[c] = (c < width && q_lines[0][c]) ? 64'd1 : 64'd0;
        end
        for (int i = 1; i < q_lines.size(); i++) begin
            nxt = m_cnt;
            for (int c = 0; c < width; c++) begin
                if (q_lines[i][c] && m_cnt[c] != 0) begin
                    m_splits++;
                    nxt[c] -= m_cnt[c];
                    if (c > 0)         nxt[c-1] += m_cnt[c];
                    if (c < width - 1) nxt[c+1] += m_cnt[c];
                end
            end
            for (int c = 0; c < width; c++) begin
                if (nxt[c] > mx) begin
                    nxt[c] = mx;
                    m_ovf  = 1'b1;
                end
            end
            m_cnt = nxt;
        end
        m_tl = 0;
        for (int c = 0; c < width; c++) m_tl += m_cnt[c];
    endfunction

    task automatic drive_lines(input logic m, input bit eof_last, input bit gaps, input int first);
        bit ok;
        int g;
        ok = 1'b1;
        tb_mode = m;
        for (int i = first; i < q_lines.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                tb_valid = 1'b0;
                tb_eof   = 1'b0;
                @(negedge clk);
            end
            tb_valid = 1'b1;
            tb_data  = q_lines[i];
            tb_eof   = eof_last && (i == q_lines.size() - 1);
            g = 0;
            while (!m_ready && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (g >= 100) ok = 1'b0;
            @(negedge clk);
        end
        tb_valid = 1'b0;
        if (!eof_last || first >= q_lines.size()) begin
            tb_eof = 1'b1;
            @(negedge clk);
        end
        tb_eof = 1'b0;
        check("line_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_result(output int lat, output int low, output logic [63:0] res, output logic ov);
        lat = 0;
        low = 0;
        while (!m_rv && lat < 200) begin
            @(negedge clk);
            lat++;
            if (!m_ready) low++;
        end
        res = m_rd;
        ov  = m_ov;
        @(negedge clk);
        check("result_valid_one_cycle", 64'(m_rv), 64'd0);
    endtask

    line_t puzzle[16] = '{16'h0080, 16'h0000, 16'h0080, 16'h0000, 16'h0140, 16'h0000,
                          16'h02A0, 16'h0000, 16'h0450, 16'h0000, 16'h0A28, 16'h0000,
                          16'h1044, 16'h0000, 16'h22AA, 16'h0000};

    initial begin
        int          lat;
        int          low;
        logic [63:0] res;
        logic        ov;
        bit          seen;
        logic        m;
        int          n;

        rst_n = 1'b0; tb_valid = 1'b0; tb_data = '0; tb_eof = 1'b0; tb_mode = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(m_ready), 64'd0);
        check("reset_result_valid", 64'(m_rv), 64'd0);
        check("reset_result_data", m_rd, 64'd0);
        check("reset_overflow", 64'(m_ov), 64'd0);
        rst_n = 1'b1;
        #1 check("ready_before_first_edge", 64'(m_ready), 64'd0);
        @(negedge clk);
        check("ready_after_release", 64'(m_ready), 64'd1);

        // Start {2}, lines {2},{1,3}
        q_lines = '{16'h0004, 16'h0004, 16'h000A};
        drive_lines(1'b0, 1'b0, 1'b0, 0);
        wait_result(lat, low, res, ov);
        check("basic_splits", res, 64'd3);
        check("basic_splits_latency", 64'(lat), 64'd2);
        check("basic_splits_overflow", 64'(ov), 64'd0);
        drive_lines(1'b1, 1'b0, 1'b0, 0);
        wait_result(lat, low, res, ov);
        check("basic_timelines", res, 64'd4);
        check("basic_timelines_latency", 64'(lat), 64'd18);
        check("basic_timelines_overflow", 64'(ov), 64'd0);

        // Beams split off column 0 leave the line
        q_lines = '{16'h0001, 16'h0001};
        drive_lines(1'b0, 1'b1, 1'b0, 0);
        wait_result(lat, low, res, ov);
        check("edge_splits", res, 64'd1);
        drive_lines(1'b1, 1'b1, 1'b0, 0);
        wait_result(lat, low, res, ov);
        check("edge_timelines", res, 64'd1);

        sel = 1;
        q_lines.delete();
        for (int i = 0; i < 16; i++) q_lines.push_back(puzzle[i]);
        drive_lines(1'b0, 1'b0, 1'b0, 0);
        wait_result(lat, low, res, ov);
        check("puzzle_splits", res, 64'd21);
        check("puzzle_splits_latency", 64'(lat), 64'd2);
        drive_lines(1'b1, 1'b0, 1'b0, 0);
        wait_result(lat, low, res, ov);
        check("puzzle_timelines", res, 64'd40);
        check("puzzle_timelines_latency", 64'(lat), 64'd17);

        sel = 2;
        q_lines = '{16'h0004, 16'h0004, 16'h000A, 16'h0004, 16'h000A};
        run_model(16, 2);
        drive_lines(1'b1, 1'b0, 1'b0, 0);
        wait_result(lat, low, res, ov);
        check("sat_overflow", 64'(ov), 64'(m_ovf));
        check("sat_column2", 64'(u_sat.r_cnt[2]), m_cnt[2]);
        check("sat_timelines", res, m_tl);

        sel = 0;
        q_lines.delete();
        drive_lines(1'b0, 1'b0, 1'b0, 0);
        wait_result(lat, low, res, ov);
        check("empty_latency", 64'(lat), 64'd1);
        check("empty_result", res, 64'd0);

        // A line held through SUM becomes the next start line
        q_lines = '{16'h0004, 16'h0004, 16'h000A};
        drive_lines(1'b1, 1'b1, 1'b0, 0);
        tb_valid = 1'b1;
        tb_data  = 16'h0100;
        wait_result(lat, low, res, ov);
        tb_valid = 1'b0;
        check("held_latency", 64'(lat), 64'd18);
        check("held_ready_low_cycles", 64'(low), 64'd17);
        check("held_prev_result", res, 64'd4);
        q_lines = '{16'h0100, 16'h0100, 16'h0280};
        run_model(16, 48);
        drive_lines(1'b1, 1'b1, 1'b0, 1);
        wait_result(lat, low, res, ov);
        check("held_new_file", res, m_tl);

        q_lines = '{16'h0004, 16'h0004, 16'h000A};
        drive_lines(1'b1, 1'b0, 1'b0, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(m_ready), 64'd0);
        check("abort_result_valid", 64'(m_rv), 64'd0);
        check("abort_result_data", m_rd, 64'd0);
        check("abort_overflow", 64'(m_ov), 64'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m_rv) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (m_rv) seen = 1'b1;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        q_lines = '{16'h0010, 16'h0010, 16'h0028, 16'h0044};
        run_model(16, 48);
        drive_lines(1'b0, 1'b0, 1'b1, 0);
        wait_result(lat, low, res, ov);
        check("after_abort_splits", res, m_splits);

        for (int t = 0; t < 10; t++) begin
            q_lines.delete();
            n = $urandom_range(1, 10);
            if ($urandom_range(0, 1) == 1) q_lines.push_back(16'h1 << $urandom_range(0, 15));
            else                           q_lines.push_back(16'($urandom));
            for (int i = 1; i < n; i++) q_lines.push_back(16'($urandom & $urandom));
            run_model(16, 48);
            m = 1'($urandom_range(0, 1));
            drive_lines(m, 1'($urandom_range(0, 1)), 1'b1, 0);
            wait_result(lat, low, res, ov);
            check("rand_result", res, m ? m_tl : m_splits);
            check("rand_latency", 64'(lat), m ? 64'd18 : 64'd2);
            check("rand_overflow", 64'(ov), 64'(m_ovf));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/beam_timeline_tracker.md
# beam_timeline_tracker

Parametrised successor to the single-mode splitter counter in the day-7 pipeline. Sits between `line_decoder` and `tap_encoder`, driven from `tck`. Consumes per-line splitter bitmaps and tracks a per-column beam multiplicity array. On end of file it reports either the number of activated splitters (part 1) or the number of distinct timelines (part 2).

## Interface
- `LINE_WIDTH`, 160, columns per line; bit index = column.
- `COUNT_WIDTH`, 48, width of each per-column timeline counter.
- `RESULT_WIDTH`, 64, width of `result_data`; must be ≥ `COUNT_WIDTH`.

- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mode` in 1: 0 = split count, 1 = timeline count; sampled when the start line is accepted.
- `line_valid` in 1: `line_data` valid.
- `line_ready` out 1: block accepts a line this cycle.
- `line_data` in `LINE_WIDTH`: first line after reset/result holds the start column(s); every later line is the splitter bitmap.
- `end_of_file` in 1: single-cycle pulse, last line already sent or sent in the same cycle.
- `result_valid` out 1: one-cycle pulse.
- `result_data` out `RESULT_WIDTH`: result, held until the next result.
- `overflow` out 1: sticky until the next start line; a counter or the sum saturated.

## Operation
- States: `START` (await start line), `ACTIVE` (splitter lines), `SUM` (serial reduction), `DONE` (pulse result, then `START`).
- Line accepted = `line_valid && line_ready`. `line_ready` = 1 in `START`/`ACTIVE`, 0 in `SUM`/`DONE`.
- START accept:
  - `cnt[c] = line_data[c]`.
  - Splits := 0, overflow := 0, latch `mode`.
  - Go to `ACTIVE`.
- ACTIVE accept, per column:
  - `hit[c] = line_data[c] && cnt[c] != 0`.
  - `cnt'[c] = (line_data[c] ? 0 : cnt[c]) + (hit[c-1] ? cnt[c-1] : 0) + (hit[c+1] ? cnt[c+1] : 0)`.
  - Columns −1 and `LINE_WIDTH` do not exist; beams leaving the edge are dropped.
  - `splits += $countones(hit)`, truncated to `RESULT_WIDTH`.
- Arithmetic: per-column sums saturate at `2**COUNT_WIDTH-1` and set `overflow`.
- `end_of_file` handling:
  - In `ACTIVE`: go to `SUM`.
  - In `START` (no lines received): go directly to `DONE` with result 0.
  - Simultaneous with an accepted line: the line is applied first, and `SUM` uses the updated array.
- SUM:
  - Mode 0: skipped; go to `DONE` with `result_data = splits`.
  - Mode 1: accumulate `cnt[0..LINE_WIDTH-1]`, one column per cycle, into a `RESULT_WIDTH` accumulator. The accumulator saturates and sets `overflow`.
- `line_valid` in `SUM`/`DONE` is not accepted and is not lost; the source holds it.

## Timing
- Reset values:
  - `line_ready` = 0 while `rst_n` is low, 1 the first cycle after release.
  - `result_valid` = 0, `result_data` = 0, `overflow` = 0, all `cnt` = 0, state `START`.
- Line update latency: 1 cycle; one line per cycle sustained in `ACTIVE`.
- `result_valid` timing, counted from the `end_of_file` edge:
  - Mode 0: 2 cycles after.
  - Mode 1: `LINE_WIDTH`+2 cycles after.
  - Empty file: 1 cycle after.
- `result_data` updates on the same edge as the `result_valid` rise.
- `rst_n` low mid-`SUM`: the sum is aborted, no `result_valid` pulse, all outputs return to their reset values asynchronously.

## Structure
- Shared package `beam_pkg`:
  - State enum `beam_state_t`.
  - Mode constants `MODE_SPLITS`, `MODE_TIMELINES`.
  - Default widths.
- One sub-module, `timeline_summer`:
  - Serial saturating accumulator over the column array.
  - Ports: start pulse, column index out, column value in, done pulse, sum, saturated flag.
- Column update is a generate loop in the top.

## Test plan
- `LINE_WIDTH`=16, mode 0/1. Start {2}, lines {2},{1,3}, eof -> mode 0 `result_data`=3, mode 1 `result_data`=4, `overflow`=0.
- Edge drop: start {0}, line {0}, eof -> splits 1, timelines 1.
- Saturation, `COUNT_WIDTH`=2: start {2}, lines {2},{1,3},{2},{1,3} -> `overflow`=1, column 2 reads 3.
- Puzzle example at `LINE_WIDTH`=15: stream the 16-line example -> mode 0 gives 21, mode 1 gives 40. Check `result_valid` latency of 2 and 17 cycles.
- `end_of_file` with no lines -> `result_valid` after 1 cycle, `result_data`=0. `line_valid` held during `SUM` -> `line_ready`=0 for `LINE_WIDTH`+1 cycles, then the line is accepted as the new start line.
- `rst_n` pulsed low 5 cycles into `SUM` -> no `result_valid`, all outputs 0. A subsequent full file produces the correct result.
